// File: rtl/div_ctrl_if.sv
// Request/response port bundle for the divider sequencer.
// The master drives requests and accepts responses; the slave is the controller.
interface div_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_sign;
    logic [DATA_W-1:0] req_dividend;
    logic [DATA_W-1:0] req_divisor;
    logic [TAG_W-1:0]  req_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_quotient;
    logic [DATA_W-1:0] rsp_remainder;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_bypass;

    modport master (
        output req_valid, req_sign, req_dividend, req_divisor, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_bypass
    );

    modport slave (
        input  req_valid, req_sign, req_dividend, req_divisor, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_bypass
    );
endinterface

// File: rtl/div_ctrl.sv
// Sequencer around the iterative subtract-shift divider: accepts a request, runs
// the divider (or resolves divide-by-zero / signed overflow locally), returns the result.
module div_ctrl #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    div_ctrl_if.slave         bus,
    output logic              busy,
    output logic              div_en,
    output logic              div_sign,
    output logic [DATA_W-1:0] div_dividend,
    output logic [DATA_W-1:0] div_divisor,
    input  logic              div_done,
    input  logic [DATA_W-1:0] div_quotient,
    input  logic [DATA_W-1:0] div_remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] SIGN_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic [DATA_W-1:0] dividend_q, dividend_d;
    logic [DATA_W-1:0] divisor_q, divisor_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              bypass_q, bypass_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              div_en_q, div_en_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        tag_d      = tag_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        bypass_d   = bypass_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    sign_d     = bus.req_sign;
                    dividend_d = bus.req_dividend;
                    divisor_d  = bus.req_divisor;
                    tag_d      = bus.req_tag;
                    if (bus.req_divisor == '0) begin
                        quot_d   = '1;
                        rem_d    = bus.req_dividend;
                        bypass_d = 1'b1;
                        state_d  = RESP;
                    end else if (bus.req_sign && bus.req_dividend == SIGN_MIN &&
                                 bus.req_divisor == '1) begin
                        quot_d   = bus.req_dividend;
                        rem_d    = '0;
                        bypass_d = 1'b1;
                        state_d  = RESP;
                    end else begin
                        bypass_d = 1'b0;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (div_done) begin
                    quot_d  = div_quotient;
                    rem_d   = div_remainder;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they track state_q exactly.
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        div_en_d    = (state_d == RUN);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            tag_q       <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            bypass_q    <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            div_en_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            tag_q       <= tag_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            bypass_q    <= bypass_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            div_en_q    <= div_en_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_quotient  = quot_q;
    assign bus.rsp_remainder = rem_q;
    assign bus.rsp_tag       = tag_q;
    assign bus.rsp_bypass    = bypass_q;

    assign busy         = busy_q;
    assign div_en       = div_en_q;
    assign div_sign     = sign_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a cycle-accurate behavioural divider model
// (done first high DATA_W+1 cycles after div_en rises).
module tb_div_ctrl;
    localparam int DW = 32;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          busy;
    logic          div_en;
    logic          div_sign;
    logic [DW-1:0] div_dividend;
    logic [DW-1:0] div_divisor;
    logic          div_done;
    logic [DW-1:0] div_quotient;
    logic [DW-1:0] div_remainder;

    div_ctrl_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

    div_ctrl #(.DATA_W(DW), .TAG_W(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .div_en       (div_en),
        .div_sign     (div_sign),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_done     (div_done),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    // Divider model: counter cleared while div_en is low.
    logic [7:0] mcnt;
    always @(posedge clk) begin
        if (!div_en) mcnt <= 8'd0;
        else         mcnt <= mcnt + 8'd1;
    end
    assign div_done = div_en && (mcnt == 8'(DW + 1));

    always_comb begin
        div_quotient  = '0;
        div_remainder = '0;
        if (div_divisor != '0) begin
            if (div_sign) begin
                div_quotient  = $signed(div_dividend) / $signed(div_divisor);
                div_remainder = $signed(div_dividend) % $signed(div_divisor);
            end else begin
                div_quotient  = div_dividend / div_divisor;
                div_remainder = div_dividend % div_divisor;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand stability / enable counting while the divider runs.
    logic          cur_sign;
    logic [DW-1:0] cur_dvd, cur_dvs;
    int en_cnt = 0;
    int op_bad = 0;
    always @(negedge clk) begin
        if (div_en) begin
            en_cnt++;
            if (div_sign !== cur_sign || div_dividend !== cur_dvd || div_divisor !== cur_dvs)
                op_bad++;
        end
    end

    typedef struct {
        logic          sign;
        logic [DW-1:0] dvd;
        logic [DW-1:0] dvs;
        logic [TW-1:0] tag;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          byp;
    } vec_t;

    vec_t vecs[8];

    task automatic do_accept(input vec_t v);
        int n;
        cur_sign = v.sign;
        cur_dvd  = v.dvd;
        cur_dvs  = v.dvs;
        en_cnt   = 0;
        op_bad   = 0;
        bus.req_valid    = 1'b1;
        bus.req_sign     = v.sign;
        bus.req_dividend = v.dvd;
        bus.req_divisor  = v.dvs;
        bus.req_tag      = v.tag;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("accept_ready", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // Called one step after the accept edge; returns edge count (accept edge = 1).
    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (!bus.rsp_valid && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic check_rsp(input vec_t v, input int cyc);
        check("latency",   cyc, v.byp ? 1 : DW + 3);
        check("quotient",  bus.rsp_quotient, v.q);
        check("remainder", bus.rsp_remainder, v.r);
        check("tag",       bus.rsp_tag, v.tag);
        check("bypass",    bus.rsp_bypass, v.byp);
        check("div_en_cycles", en_cnt, v.byp ? 0 : DW + 2);
        check("div_operands_stable", op_bad, 0);
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("idle_after_rsp", {bus.rsp_valid, bus.req_ready, busy, div_en}, 4'b0100);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        do_accept(v);
        wait_rsp(cyc);
        check_rsp(v, cyc);
        finish_rsp();
    endtask

    initial begin
        vec_t va, vb;
        int   cyc;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          4'd3,  32'd14,         32'd2,          1'b0};
        vecs[1] = '{1'b1, 32'hFFFFFF9C,   32'd7,          4'd5,  32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
        vecs[2] = '{1'b0, 32'h1234,       32'd0,          4'd1,  32'hFFFFFFFF,   32'h1234,       1'b1};
        vecs[3] = '{1'b1, 32'h1234,       32'd0,          4'd2,  32'hFFFFFFFF,   32'h1234,       1'b1};
        vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   4'd7,  32'h80000000,   32'd0,          1'b1};
        vecs[5] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   4'd8,  32'd0,          32'h80000000,   1'b0};
        vecs[6] = '{1'b1, 32'd100,        32'hFFFFFFF9,   4'd9,  32'hFFFFFFF2,   32'd2,          1'b0};
        vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'h10,         4'd15, 32'h0FFFFFFF,   32'hF,          1'b0};

        bus.req_valid    = 1'b0;
        bus.req_sign     = 1'b0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.req_tag      = '0;
        bus.rsp_ready    = 1'b0;

        #12;
        check("reset_state", {bus.rsp_valid, busy, div_en, bus.rsp_bypass, bus.rsp_quotient, bus.rsp_tag},
              {1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0});
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", {bus.req_ready, busy}, 2'b10);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure with a new request waiting behind the held response.
        va = '{1'b0, 32'd100, 32'd7, 4'd4, 32'd14, 32'd2, 1'b0};
        vb = '{1'b0, 32'd50,  32'd5, 4'd6, 32'd10, 32'd0, 1'b0};
        do_accept(va);
        wait_rsp(cyc);
        check_rsp(va, cyc);
        bus.req_valid    = 1'b1;
        bus.req_sign     = vb.sign;
        bus.req_dividend = vb.dvd;
        bus.req_divisor  = vb.dvs;
        bus.req_tag      = vb.tag;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_hold", {bus.req_ready, bus.rsp_valid, div_en, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_tag, bus.rsp_bypass},
                  {1'b0, 1'b1, 1'b0, 32'd14, 32'd2, 4'd4, 1'b0});
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("bp_idle_gap", {bus.req_ready, div_en, bus.rsp_valid}, 3'b100);
        cur_sign = vb.sign; cur_dvd = vb.dvd; cur_dvs = vb.dvs;
        en_cnt = 0; op_bad = 0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("bp_next_started", {div_en, bus.req_ready}, 2'b10);
        wait_rsp(cyc);
        check_rsp(vb, cyc);
        finish_rsp();

        // Reset in the middle of a normal division.
        va = '{1'b0, 32'd1000, 32'd3, 4'd11, 32'd333, 32'd1, 1'b0};
        do_accept(va);
        repeat (9) begin @(posedge clk); #1; end
        check("mid_run_before_rst", {div_en, busy}, 2'b11);
        rst = 1'b1;
        #1;
        check("mid_run_reset", {div_en, bus.rsp_valid, busy, bus.rsp_quotient, bus.rsp_tag},
              {1'b0, 1'b0, 1'b0, 32'd0, 4'd0});
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_mid_reset", {bus.req_ready, busy, div_en}, 3'b100);
        run_vec('{1'b0, 32'd50, 32'd5, 4'd10, 32'd10, 32'd0, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
